hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Operand-forwarding and load-use hazard controller for the 5-stage RISC-V core. Tracks the destination registers of the instructions in EX, MEM and WB. Produces registered 2-bit select codes for the EX-stage operand A/B 4-input muxes. Raises a combinational stall to the fetch/decode registers on load-use hazards and counts stall cycles.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`, in, 1: core clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `id_valid`, in, 1: valid instruction in ID.
- `id_rs1`, `id_rs2`, in, REG_AW: ID source registers.
- `id_rs1_used`, `id_rs2_used`, in, 1: source actually read by the instruction.
- `id_rd`, in, REG_AW: ID destination register.
- `id_rd_we`, in, 1: ID instruction writes rd.
- `id_is_load`, in, 1: ID instruction is a load.
- `flush`, in, 1: branch/jump redirect; kills the ID instruction.
- `stall`, out, 1: hold PC and IF/ID; combinational.
- `ex_valid`, out, 1: EX holds a real instruction; registered.
- `ex_fwd_a_sel`, `ex_fwd_b_sel`, out, 2: EX operand mux selects; registered.
- `stall_cnt`, out, CNT_W: saturating count of stall cycles.

Select encoding:
- `00` = register file.
- `01` = EX/MEM ALU result.
- `10` = MEM/WB result (ALU or load data).
- `11` = WB retire bypass register.

## Operation
- Three tracking slots, EX, MEM and WB. Each slot holds {valid, rd, we, load}.
- A slot "writes r" iff valid && we && rd==r && r!=0.
- Slot advance, every cycle:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields if id_valid && !stall && !flush; otherwise a bubble (valid=0, we=0, load=0).
- Select for each source s∈{rs1,rs2}, registered into EX alongside the EX slot:
  - If !used, or s==0, or the EX slot gets a bubble, the select is 00.
  - Else if the current EX slot writes s: 01.
  - Else if the current MEM slot writes s: 10.
  - Else if the current WB slot writes s: 11.
  - Else 00.
  - Youngest producer wins.
- Load-use stall:
  - `stall` = id_valid && !flush && EX.load && EX writes (id_rs1 with id_rs1_used, or id_rs2 with id_rs2_used).
  - A stalled ID instruction re-evaluates next cycle. The load is then in MEM, so the select resolves to 10.
- Flush:
  - Forces a bubble into EX and overrides stall (stall=0 while flush=1).
  - MEM and WB still advance.
- `ex_valid` = EX slot valid bit.
- `stall_cnt` increments on each cycle with stall=1 and saturates at all-ones. It never wraps.

## Timing
- Reset (async, immediate):
  - All slots invalid.
  - ex_valid=0, both selects 00, stall_cnt=0.
  - stall therefore 0.
- Release of reset is synchronous to `clk` by the surrounding reset logic. No instruction is captured on the edge where rst is high.
- Select latency: ID inputs at cycle N produce ex_fwd_*_sel valid throughout cycle N+1, with the instruction in EX.
- stall is purely combinational from ID inputs and the EX slot, and is valid in the same cycle.
- One load-use hazard costs exactly one stall cycle. A back-to-back dependent load chain costs one stall per dependent pair.
- Simultaneous stall condition and flush: flush wins, no stall counted.
- Reset asserted mid-operation discards all slots. The first post-reset instruction sees selects 00.

## Test plan
- Back-to-back ALU dependency: `add x5` then `sub` reading rs1=x5 (used) -> ex_fwd_a_sel=01 in the sub's EX cycle, ex_fwd_b_sel=00, stall never asserted.
- Distance 2 and 3: producer writes x7, then one or two independent instructions, then a consumer with rs2=x7 -> ex_fwd_b_sel=10 at distance 2 and 11 at distance 3. At distance 4 the select is 00.
- Load-use: `lw x3`, then `add` reading rs1=x3:
  - stall=1 for exactly one cycle, stall_cnt 0->1, ex_valid=0 in the bubble cycle.
  - Next cycle ex_fwd_a_sel=10.
- x0 and unused sources:
  - Producer writes x0 (we=1), consumer reads x0 -> select 00.
  - rs2=x5 matches the EX slot but id_rs2_used=0 -> ex_fwd_b_sel=00.
- Flush during hazard: load in EX, dependent instruction in ID, flush=1 -> stall=0, stall_cnt unchanged, next EX is a bubble with ex_valid=0.
- Saturation and reset: with CNT_W=4, force 20 stall cycles -> stall_cnt holds 15. Assert rst asynchronously mid-cycle -> stall_cnt=0, selects 00, ex_valid=0 before the next edge.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Operand-forwarding and load-use hazard controller for the 5-stage core.
// Tracks the destination registers of the instructions in EX, MEM and WB,
// produces registered select codes for the EX operand muxes, raises a
// combinational load-use stall and keeps a saturating count of stall cycles.
//
// Select encoding: 00 register file, 01 EX/MEM ALU result,
//                  10 MEM/WB result, 11 WB retire bypass register.
module hazard_fwd_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Tracking slots. Only the EX slot needs its load flag: a load is a
  // hazard only while it sits in EX, so MEM and WB do not carry it.
  logic              ex_v, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_we;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_v, wb_we;
  logic [REG_AW-1:0] wb_rd;

  logic              capture;
  logic [1:0]        sel_a_next, sel_b_next;
  logic              ex_wr_rs1, ex_wr_rs2;
  logic              mem_wr_rs1, mem_wr_rs2;
  logic              wb_wr_rs1, wb_wr_rs2;

  // A slot writes register r when it is live, writes, and r is not x0.
  function automatic logic slot_writes(input logic v, input logic we,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
    return v && we && (rd == r) && (r != '0);
  endfunction

  // Producer-match terms for both ID sources against every slot.
  always_comb begin
    ex_wr_rs1  = slot_writes(ex_v,  ex_we,  ex_rd,  id_rs1);
    ex_wr_rs2  = slot_writes(ex_v,  ex_we,  ex_rd,  id_rs2);
    mem_wr_rs1 = slot_writes(mem_v, mem_we, mem_rd, id_rs1);
    mem_wr_rs2 = slot_writes(mem_v, mem_we, mem_rd, id_rs2);
    wb_wr_rs1  = slot_writes(wb_v,  wb_we,  wb_rd,  id_rs1);
    wb_wr_rs2  = slot_writes(wb_v,  wb_we,  wb_rd,  id_rs2);
  end

  // Load-use stall: a load in EX feeds a source the ID instruction reads; flush wins.
  always_comb begin
    stall   = id_valid && !flush && ex_ld &&
              ((id_rs1_used && ex_wr_rs1) || (id_rs2_used && ex_wr_rs2));
    capture = id_valid && !stall && !flush;
  end

  // Operand A select: youngest producer wins, bubbles and unused sources get 00.
  always_comb begin
    sel_a_next = 2'b00;
    if (capture && id_rs1_used && (id_rs1 != '0)) begin
      if (ex_wr_rs1)       sel_a_next = 2'b01;
      else if (mem_wr_rs1) sel_a_next = 2'b10;
      else if (wb_wr_rs1)  sel_a_next = 2'b11;
    end
  end

  // Operand B select: same priority as operand A.
  always_comb begin
    sel_b_next = 2'b00;
    if (capture && id_rs2_used && (id_rs2 != '0)) begin
      if (ex_wr_rs2)       sel_b_next = 2'b01;
      else if (mem_wr_rs2) sel_b_next = 2'b10;
      else if (wb_wr_rs2)  sel_b_next = 2'b11;
    end
  end

  // Advance the pipeline slots and register the selects alongside the EX slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v         <= 1'b0;
      ex_we        <= 1'b0;
      ex_ld        <= 1'b0;
      ex_rd        <= '0;
      mem_v        <= 1'b0;
      mem_we       <= 1'b0;
      mem_rd       <= '0;
      wb_v         <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      ex_fwd_a_sel <= 2'b00;
      ex_fwd_b_sel <= 2'b00;
    end else begin
      wb_v   <= mem_v;
      wb_we  <= mem_we;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      if (capture) begin
        ex_v  <= 1'b1;
        ex_we <= id_rd_we;
        ex_ld <= id_is_load;
        ex_rd <= id_rd;
      end else begin
        ex_v  <= 1'b0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
      end
      ex_fwd_a_sel <= sel_a_next;
      ex_fwd_b_sel <= sel_b_next;
    end
  end

  // Saturating stall-cycle counter; it holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid = ex_v;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// Directed bench for hazard_fwd_unit, instantiated with a 4-bit stall
// counter so saturation is reachable quickly. Inputs change on the falling
// edge; stall is sampled mid-cycle, registered outputs 1ns after the rising edge.
module tb_hazard_fwd_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [1:0]        ex_fwd_a_sel, ex_fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_fwd_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_fwd_a_sel (ex_fwd_a_sel),
    .ex_fwd_b_sel (ex_fwd_b_sel),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait for the falling edge, then present one instruction in ID.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld);
    @(negedge clk);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rd_we    = we;
    id_is_load  = ld;
    flush       = 1'b0;
  endtask

  // Let the rising edge happen and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Synchronous-release reset with ID idle.
  task automatic do_reset;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid: got %b expected 0", ex_valid); end
    checks++;
    if (ex_fwd_a_sel !== 2'b00 || ex_fwd_b_sel !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_sel: got a=%b b=%b expected 00/00", ex_fwd_a_sel, ex_fwd_b_sel);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5, x1, x2
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);   // sub x8, x5, x6
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (ex_fwd_a_sel !== 2'b01) begin errors++; $display("[TB] FAIL b2b_sel_a: got %b expected 01", ex_fwd_a_sel); end
    checks++;
    if (ex_fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL b2b_sel_b: got %b expected 00", ex_fwd_b_sel); end
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ex_valid: got %b expected 1", ex_valid); end
  endtask

  task automatic test_distance;
    logic [1:0] exp_sel [2:4];
    exp_sel[2] = 2'b10;
    exp_sel[3] = 2'b11;
    exp_sel[4] = 2'b00;
    for (int d = 2; d <= 4; d++) begin
      do_reset();
      issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // producer of x7
      tick();
      for (int k = 1; k < d; k++) begin
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); // independent
        tick();
      end
      issue(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0);   // consumer rs2=x7
      tick();
      checks++;
      if (ex_fwd_b_sel !== exp_sel[d]) begin
        errors++; $display("[TB] FAIL dist%0d_sel_b: got %b expected %b", d, ex_fwd_b_sel, exp_sel[d]);
      end
    end
  endtask

  task automatic test_load_use;
    do_reset();
    issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6, x3, x4
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall_on: got %b expected 1", stall); end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL lu_cnt_before: got %0d expected 0", stall_cnt); end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_valid: got %b expected 0", ex_valid); end
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("[TB] FAIL lu_cnt_after: got %0d expected 1", stall_cnt); end
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_off: got %b expected 0", stall); end
    tick();
    checks++;
    if (ex_fwd_a_sel !== 2'b10) begin errors++; $display("[TB] FAIL lu_sel_a: got %b expected 10", ex_fwd_a_sel); end
    checks++;
    if (ex_valid !== 1'b1 || stall_cnt !== 4'd1) begin
      errors++; $display("[TB] FAIL lu_resume: got valid=%b cnt=%0d expected 1/1", ex_valid, stall_cnt);
    end
  endtask

  task automatic test_x0_unused;
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);   // writes x0
    tick();
    issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);   // reads x0
    tick();
    checks++;
    if (ex_fwd_a_sel !== 2'b00 || ex_fwd_b_sel !== 2'b00) begin
      errors++; $display("[TB] FAIL x0_sel: got a=%b b=%b expected 00/00", ex_fwd_a_sel, ex_fwd_b_sel);
    end
    do_reset();
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // writes x5
    tick();
    issue(1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 5'd9, 1'b1, 1'b0);   // rs2=x5 unused
    tick();
    checks++;
    if (ex_fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL unused_sel_b: got %b expected 00", ex_fwd_b_sel); end
    issue(1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0);  // rs2=x9 used, x9 in EX
    tick();
    checks++;
    if (ex_fwd_b_sel !== 2'b01) begin errors++; $display("[TB] FAIL used_sel_b: got %b expected 01", ex_fwd_b_sel); end
  endtask

  task automatic test_flush;
    do_reset();
    issue(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
    tick();
    issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);   // dependent add
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ex_valid: got %b expected 0", ex_valid); end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL flush_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_saturation_reset;
    int stalls = 0;
    logic exp_stall;
    do_reset();
    // A load that reads its own destination stalls every other cycle.
    issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      #1;
      exp_stall = (i % 2 == 1);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("[TB] FAIL sat_stall_%0d: got %b expected %b", i, stall, exp_stall);
      end
      if (exp_stall) stalls++;
      tick();
      checks++;
      if (stall_cnt !== CNT_W'((stalls > 15) ? 15 : stalls)) begin
        errors++; $display("[TB] FAIL sat_cnt_%0d: got %0d expected %0d", i, stall_cnt, (stalls > 15) ? 15 : stalls);
      end
      @(negedge clk);
    end
    checks++;
    if (stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 15", stall_cnt); end
    // Build up a non-zero forwarding state, then reset mid-cycle.
    issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_fwd_a_sel !== 2'b01 || ex_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_rst_state: got a=%b valid=%b expected 01/1", ex_fwd_a_sel, ex_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL async_rst_cnt: got %0d expected 0", stall_cnt); end
    checks++;
    if (ex_fwd_a_sel !== 2'b00 || ex_fwd_b_sel !== 2'b00 || ex_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL async_rst_out: got a=%b b=%b valid=%b expected 00/00/0",
                         ex_fwd_a_sel, ex_fwd_b_sel, ex_valid);
    end
    // First instruction after reset must not see the discarded x5 producers.
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_fwd_a_sel !== 2'b00 || ex_fwd_b_sel !== 2'b00 || ex_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL post_rst_sel: got a=%b b=%b valid=%b expected 00/00/1",
                         ex_fwd_a_sel, ex_fwd_b_sel, ex_valid);
    end
  endtask

  initial begin
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_we = 1'b0; id_is_load = 1'b0;
    flush = 1'b0;
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
